img_stream_sched: RTL and testbench

IMG_STREAM_SCHED -- requirements
Module: img_stream_sched

---
 rtl/img_stream_sched.sv | 187 ++++++++++++++++++
 tb/tb_img_stream_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_stream_sched.sv
`default_nettype none
// ============================================================================
// Module   : img_stream_sched
// Purpose  : Raster read/write scheduler for a KWxKW stencil streaming app.
//            Optional stall counter enabled by defining SCHED_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module img_stream_sched #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int KW       = 3,
  parameter int PIPE_LAT = 4,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          start,
  input  logic          src_valid,
  output logic          read_en,
  output logic          write_valid,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic          busy,
  output logic          done
`ifdef SCHED_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);

  localparam logic [CW-1:0] c_in_x_last  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] c_in_y_last  = CW'(IMG_H - 1);
  localparam logic [CW-1:0] c_out_x_last = CW'(IMG_W - KW);
  localparam logic [CW-1:0] c_win_min    = CW'(KW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_read;
  logic                  w_in_last;
  logic                  w_push;
  logic                  w_start_go;
  logic                  w_shift_en;
  logic [CW-1:0]         r_in_x;
  logic [CW-1:0]         r_in_y;
  logic [CW-1:0]         r_out_x;
  logic [CW-1:0]         r_out_y;
  logic [PIPE_LAT-1:0]   r_vld_sr;

  assign w_in_last  = (r_in_x == c_in_x_last) && (r_in_y == c_in_y_last);
  assign w_start_go = (r_state == S_IDLE) && start && !flush;
  assign w_shift_en = (r_state == S_RUN) || (r_state == S_DRAIN);
  // Only reads whose full stencil window is already available produce an output.
  assign w_push     = w_read && (r_in_x >= c_win_min) && (r_in_y >= c_win_min);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_read       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        w_read = src_valid;
        if (src_valid && w_in_last) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_vld_sr == '0) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (flush) begin
      w_next_state = S_IDLE;
    end
  end

  // Input raster position of the next off-chip read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_x <= '0;
      r_in_y <= '0;
    end else if (flush || w_start_go) begin
      r_in_x <= '0;
      r_in_y <= '0;
    end else if (w_read) begin
      if (r_in_x == c_in_x_last) begin
        r_in_x <= '0;
        r_in_y <= r_in_y + CW'(1);
      end else begin
        r_in_x <= r_in_x + CW'(1);
      end
    end
  end

  generate
    if (PIPE_LAT == 1) begin : g_sr_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld_sr <= '0;
        end else if (flush || w_start_go) begin
          r_vld_sr <= '0;
        end else if (w_shift_en) begin
          r_vld_sr <= w_push;
        end
      end
    end else begin : g_sr_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld_sr <= '0;
        end else if (flush || w_start_go) begin
          r_vld_sr <= '0;
        end else if (w_shift_en) begin
          r_vld_sr <= {r_vld_sr[PIPE_LAT-2:0], w_push};
        end
      end
    end
  endgenerate

  // Output raster position, advanced once per emitted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_x <= '0;
      r_out_y <= '0;
    end else if (flush || w_start_go) begin
      r_out_x <= '0;
      r_out_y <= '0;
    end else if (write_valid) begin
      if (r_out_x == c_out_x_last) begin
        r_out_x <= '0;
        r_out_y <= r_out_y + CW'(1);
      end else begin
        r_out_x <= r_out_x + CW'(1);
      end
    end
  end

`ifdef SCHED_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (flush || w_start_go) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_RUN) && !src_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

  assign read_en     = w_read;
  assign write_valid = r_vld_sr[PIPE_LAT-1];
  assign out_x       = r_out_x;
  assign out_y       = r_out_y;
  assign busy        = w_shift_en;
  assign done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_img_stream_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_img_stream_sched
// Purpose  : Randomized scoreboard bench for img_stream_sched (8x4, KW=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_img_stream_sched;

  localparam int IMG_W    = 8;
  localparam int IMG_H    = 4;
  localparam int KW       = 3;
  localparam int PIPE_LAT = 4;
  localparam int CW       = 16;
  localparam int NPIX     = IMG_W * IMG_H;
  localparam int NOUT     = (IMG_W - KW + 1) * (IMG_H - KW + 1);
  localparam int NEVER    = 1 << 30;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          start = 1'b0;
  logic          src_valid = 1'b0;
  logic          read_en;
  logic          write_valid;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic          busy;
  logic          done;
`ifdef SCHED_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  img_stream_sched #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .KW      (KW),
    .PIPE_LAT(PIPE_LAT),
    .CW      (CW)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .start      (start),
    .src_valid  (src_valid),
    .read_en    (read_en),
    .write_valid(write_valid),
    .out_x      (out_x),
    .out_y      (out_y),
    .busy       (busy),
    .done       (done)
`ifdef SCHED_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int x;
    int y;
  } wexp_t;

  wexp_t wq[$];
  int    dq[$];
  wexp_t mon_e;
  int    mon_d;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: frame progress expressed as a read count plus expected event cycles.
  bit m_run = 1'b0;
  int m_reads = 0;
  int m_busy_lo = NEVER;
  int m_busy_hi = -1;
  int m_idle_from = 0;
  int m_stall = 0;
  int last_c = 0;

  int f0 = 0;
  int rd_seen, rd_first, rd_last, wr_seen, wr_first, done_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act);
    n_chk++;
    $display("FAIL %s: got %0d, required no event (cycle %0d)", name, $signed(act), cyc);
  endtask

  task automatic clear_stats();
    rd_seen   = 0;
    rd_first  = -1;
    rd_last   = -1;
    wr_seen   = 0;
    wr_first  = -1;
    done_seen = -1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits a pixel or a done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (write_valid === 1'b1) begin
        wr_seen++;
        if (wr_first < 0) wr_first = cyc;
        if (wq.size() == 0) begin
          fail("write_unexpected", cyc);
        end else begin
          mon_e = wq.pop_front();
          chk("write_cycle", cyc, mon_e.c);
          chk("out_x", out_x, mon_e.x);
          chk("out_y", out_y, mon_e.y);
        end
      end
      if (done === 1'b1) begin
        done_seen = cyc;
        if (dq.size() == 0) begin
          fail("done_unexpected", cyc);
        end else begin
          mon_d = dq.pop_front();
          chk("done_cycle", cyc, mon_d);
        end
      end
    end
  end

  task automatic step(input bit sv, input bit st, input bit fl);
    int  c;
    int  x;
    int  y;
    bit  exp_rd;
    bit  exp_busy;
    @(negedge clk);
    c = cyc;
    last_c = c;
    src_valid = sv;
    start = st;
    flush = fl;
    exp_rd = m_run && sv;
    exp_busy = (c >= m_busy_lo) && (c <= m_busy_hi);
    if (m_run && !sv) m_stall++;
    if (exp_rd) begin
      x = m_reads % IMG_W;
      y = m_reads / IMG_W;
      if (x >= KW - 1 && y >= KW - 1) wq.push_back('{c + PIPE_LAT, x - (KW - 1), y - (KW - 1)});
      m_reads++;
      if (m_reads == NPIX) begin
        m_run = 1'b0;
        m_busy_hi = c + PIPE_LAT + 1;
        dq.push_back(c + PIPE_LAT + 2);
        m_idle_from = c + PIPE_LAT + 3;
      end
    end
    if (fl) begin
      m_run = 1'b0;
      if (m_busy_hi > c) m_busy_hi = c;
      m_idle_from = c + 1;
      while (wq.size() > 0 && wq[$].c > c) void'(wq.pop_back());
      while (dq.size() > 0 && dq[$] > c) void'(dq.pop_back());
    end else if (st && c >= m_idle_from) begin
      m_run = 1'b1;
      m_reads = 0;
      m_stall = 0;
      m_busy_lo = c + 1;
      m_busy_hi = NEVER;
      m_idle_from = NEVER;
      f0 = c;
    end
    #1;
    if (read_en === 1'b1) begin
      rd_seen++;
      if (rd_first < 0) rd_first = c;
      rd_last = c;
    end
    chk("read_en", read_en, exp_rd);
    chk("busy", busy, exp_busy);
  endtask

  // mode 0: src_valid always 1; mode 1: low every 4th cycle; mode 2: random with stray starts.
  task automatic run_frame(input int mode);
    bit sv;
    bit st;
    bit ended;
    clear_stats();
    ended = 1'b0;
    step(1'($urandom), 1'b1, 1'b0);
    for (int k = 1; k < 1000; k++) begin
      case (mode)
        0:       sv = 1'b1;
        1:       sv = ((k % 4) != 3);
        default: sv = ($urandom_range(3) != 0);
      endcase
      st = (mode == 2) ? ($urandom_range(7) == 0) : 1'b0;
      step(sv, st, 1'b0);
      if (last_c + 1 >= m_idle_from) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) fail("frame_timeout", last_c);
    chk("frame_reads", rd_seen, NPIX);
    chk("frame_writes", wr_seen, NOUT);
    chk("frame_wq_left", wq.size(), 0);
    chk("frame_dq_left", dq.size(), 0);
    if (mode == 0) begin
      chk("first_read_cycle", rd_first - f0, 1);
      chk("last_read_cycle", rd_last - f0, 32);
      chk("first_write_cycle", wr_first - f0, 23);
      chk("done_frame_cycle", done_seen - f0, 38);
    end
`ifdef SCHED_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
`endif
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_read_en"}, read_en, 0);
    chk({tag, "_write_valid"}, write_valid, 0);
    chk({tag, "_out_x"}, out_x, 0);
    chk({tag, "_out_y"}, out_y, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_reads = 0;
    m_busy_lo = NEVER;
    m_busy_hi = -1;
    m_idle_from = 0;
    wq.delete();
    dq.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_at;
    int guard;
    clear_stats();
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);

    run_frame(0);
    run_frame(1);
    for (int k = 0; k < 3; k++) run_frame(2);

    // Flush in frame cycle 15 while start is held high.
    clear_stats();
    for (int k = 0; k <= 14; k++) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    wr_at = wr_seen;
    for (int k = 16; k < 50; k++) step(1'b1, 1'b0, 1'b0);
    chk("flush_writes_after", wr_seen - wr_at, 0);
    chk("flush_done", done_seen, -1);
    chk("flush_reads", rd_seen, 15);
    chk("flush_wq_left", wq.size(), 0);

    run_frame(0);

    // Asynchronous reset while draining, timed onto a write_valid cycle.
    clear_stats();
    step(1'b1, 1'b1, 1'b0);
    guard = 0;
    while (m_reads < NPIX && guard < 200) begin
      step(1'b1, 1'b0, 1'b0);
      guard++;
    end
    for (int k = 0; k < PIPE_LAT; k++) step(1'b1, 1'b0, 1'b0);
    chk("drain_busy_before_reset", busy, 1);
    chk("drain_write_before_reset", write_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("drain_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
    run_frame(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
